// File: rtl/frame_clearer_if.sv
// Frame-buffer clear port: request/handshake inputs and presented-pixel outputs.
// master = the clearer that presents pixels, slave = frame control / memory side.
interface frame_clearer_if;
    logic        clear_start;
    logic        mem_ready;
    logic [9:0]  clear_DrawX;
    logic [9:0]  clear_DrawY;
    logic        pixel_we;
    logic [15:0] pixel_color;
    logic        clear_done;

    modport master (
        input  clear_start,
        input  mem_ready,
        output clear_DrawX,
        output clear_DrawY,
        output pixel_we,
        output pixel_color,
        output clear_done
    );

    modport slave (
        output clear_start,
        output mem_ready,
        input  clear_DrawX,
        input  clear_DrawY,
        input  pixel_we,
        input  pixel_color,
        input  clear_done
    );
endinterface

// File: rtl/frame_clearer.sv
// frame_clearer: walks the frame in raster order presenting one background
// pixel per cycle, advancing only when the write port accepts it.
// Optional macro CLEAR_CHECKER_EN: checkerboard background of CLEAR_COLOR /
// ALT_COLOR squares of 2**CHECK_SHIFT pixels; otherwise a flat CLEAR_COLOR.
module frame_clearer #(
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000,
    parameter logic [15:0] ALT_COLOR   = 16'h4208,
    parameter int          CHECK_SHIFT = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    frame_clearer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [9:0] Y_MAX = 10'(V_RES - 1);

`ifdef CLEAR_CHECKER_EN
    localparam bit CHECKER_ON = 1'b1;
`else
    localparam bit CHECKER_ON = 1'b0;
`endif

    state_t     state_reg, state_next;
    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;

    logic accept;
    logic last_x;
    logic last_pixel;
    logic checker_hit;

    assign accept     = (state_reg == RUN) && bus.mem_ready;
    assign last_x     = (x_reg == X_MAX);
    assign last_pixel = last_x && (y_reg == Y_MAX);

    // State and scan counters; reset returns to an empty Idle immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    // Next state and counter update. Counters are zeroed on every exit from
    // Run, so they are already 0 when the next clear begins.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clear_start) begin
                    state_next = RUN;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            RUN: begin
                if (accept && last_pixel) begin
                    // Final acceptance wins over a simultaneous abort.
                    state_next = DONE;
                    x_next     = '0;
                    y_next     = '0;
                end else if (!bus.clear_start) begin
                    // Abort: any pending unaccepted pixel is dropped.
                    state_next = IDLE;
                    x_next     = '0;
                    y_next     = '0;
                end else if (accept) begin
                    if (last_x) begin
                        x_next = '0;
                        y_next = y_reg + 10'd1;
                    end else begin
                        x_next = x_reg + 10'd1;
                    end
                end
            end
            DONE: begin
                if (!bus.clear_start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                x_next     = '0;
                y_next     = '0;
            end
        endcase
    end

    // Outputs decode registered state only; a stall simply holds the counters.
    assign checker_hit     = CHECKER_ON && (x_reg[CHECK_SHIFT] ^ y_reg[CHECK_SHIFT]);
    assign bus.pixel_we    = (state_reg == RUN);
    assign bus.clear_done  = (state_reg == DONE);
    assign bus.clear_DrawX = x_reg;
    assign bus.clear_DrawY = y_reg;
    assign bus.pixel_color = ((state_reg == RUN) && checker_hit) ? ALT_COLOR : CLEAR_COLOR;

endmodule

// File: tb/tb_frame_clearer.sv
// Directed bench for frame_clearer on a reduced 40x40 frame: reset, full
// clear, backpressure, abort/restart, async reset mid-run, final-pixel abort.
module tb_frame_clearer;

    localparam int          H     = 40;
    localparam int          V     = 40;
    localparam int          N     = H * V;
    localparam logic [15:0] C_CLR = 16'h001F;
    localparam logic [15:0] C_ALT = 16'h4208;

`ifdef CLEAR_CHECKER_EN
    localparam bit TB_CHK = 1'b1;
`else
    localparam bit TB_CHK = 1'b0;
`endif

    // Hand-computed colours at the checker probe points.
    localparam logic [15:0] EXP_0_0   = C_CLR;
    localparam logic [15:0] EXP_32_0  = TB_CHK ? C_ALT : C_CLR;
    localparam logic [15:0] EXP_32_32 = C_CLR;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    frame_clearer_if bus ();

    frame_clearer #(
        .H_RES       (H),
        .V_RES       (V),
        .CLEAR_COLOR (C_CLR),
        .ALT_COLOR   (C_ALT),
        .CHECK_SHIFT (5)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Checkerboard parity via square indices (sum parity == bit XOR).
    function automatic logic [15:0] exp_color(input int x, input int y);
        logic odd;
        odd = (((x / 32) + (y / 32)) % 2) == 1;
        return (TB_CHK && odd) ? C_ALT : C_CLR;
    endfunction

    // Compare presented pixel against raster index idx; tally mismatches.
    task automatic cmp_pixel(input int idx, inout int bad);
        int ex;
        int ey;
        ex = idx % H;
        ey = idx / H;
        if (bus.pixel_we !== 1'b1 || bus.clear_DrawX !== 10'(ex) ||
            bus.clear_DrawY !== 10'(ey) || bus.pixel_color !== exp_color(ex, ey)) begin
            if (bad == 0)
                $display("first bad pixel idx=%0d we=%0b x=%0d y=%0d color=%0h", idx,
                         bus.pixel_we, bus.clear_DrawX, bus.clear_DrawY, bus.pixel_color);
            bad++;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int        bad;
        int        acc;
        int        cyc;
        logic [3:0] pat;

        pat             = 4'b1001;
        bus.clear_start = 1'b0;
        bus.mem_ready   = 1'b0;

        // Reset state, sampled while Reset is held.
        #12;
        check("rst_we",    32'(bus.pixel_we),    32'd0);
        check("rst_done",  32'(bus.clear_done),  32'd0);
        check("rst_x",     32'(bus.clear_DrawX), 32'd0);
        check("rst_y",     32'(bus.clear_DrawY), 32'd0);
        check("rst_color", 32'(bus.pixel_color), 32'(C_CLR));
        @(negedge Clk);
        Reset = 1'b0;
        step();
        check("idle_we", 32'(bus.pixel_we), 32'd0);

        // Full clear, mem_ready tied high.
        bus.clear_start = 1'b1;
        bus.mem_ready   = 1'b1;
        check("pre_run_we", 32'(bus.pixel_we), 32'd0);
        step();
        bad = 0;
        for (int i = 0; i < N; i++) begin
            cmp_pixel(i, bad);
            if (i == 0)
                check("chk_0_0", 32'(bus.pixel_color), 32'(EXP_0_0));
            if (i == 32)
                check("chk_32_0", 32'(bus.pixel_color), 32'(EXP_32_0));
            if (i == 32 * H + 32)
                check("chk_32_32", 32'(bus.pixel_color), 32'(EXP_32_32));
            step();
        end
        check("full_bad",  32'(bad),             32'd0);
        check("full_done", 32'(bus.clear_done),  32'd1);
        check("full_we",   32'(bus.pixel_we),    32'd0);
        step();
        check("hold_done", 32'(bus.clear_done),  32'd1);
        bus.clear_start = 1'b0;
        step();
        check("exit_done", 32'(bus.clear_done),  32'd0);
        check("exit_we",   32'(bus.pixel_we),    32'd0);
        $display("full clear: %0d pixels scanned, bad=%0d", N, bad);

        // Backpressure: mem_ready 1,0,0,1 repeating.
        bus.clear_start = 1'b1;
        step();
        acc = 0;
        cyc = 0;
        bad = 0;
        while (acc < N && cyc < 8 * N) begin
            bus.mem_ready = pat[cyc % 4];
            cmp_pixel(acc, bad);
            if (bus.mem_ready) acc++;
            step();
            cyc++;
        end
        check("bp_acc",    32'(acc),            32'(N));
        check("bp_bad",    32'(bad),            32'd0);
        check("bp_cycles", 32'(cyc),            32'd3200);
        check("bp_done",   32'(bus.clear_done), 32'd1);
        bus.clear_start = 1'b0;
        bus.mem_ready   = 1'b1;
        step();
        check("bp_idle", 32'(bus.clear_done), 32'd0);
        $display("backpressure: acc=%0d cycles=%0d bad=%0d", acc, cyc, bad);

        // Abort after acceptance of (10,2), with the next pixel pending.
        bus.clear_start = 1'b1;
        step();
        bad = 0;
        for (int i = 0; i <= 2 * H + 10; i++) begin
            cmp_pixel(i, bad);
            step();
        end
        check("ab_bad", 32'(bad),             32'd0);
        check("ab_x11", 32'(bus.clear_DrawX), 32'd11);
        bus.clear_start = 1'b0;
        bus.mem_ready   = 1'b0;
        step();
        check("ab_we",   32'(bus.pixel_we),    32'd0);
        check("ab_done", 32'(bus.clear_done),  32'd0);
        check("ab_x",    32'(bus.clear_DrawX), 32'd0);
        check("ab_y",    32'(bus.clear_DrawY), 32'd0);
        bus.clear_start = 1'b1;
        bus.mem_ready   = 1'b1;
        step();
        check("rs_we", 32'(bus.pixel_we),    32'd1);
        check("rs_x",  32'(bus.clear_DrawX), 32'd0);
        check("rs_y",  32'(bus.clear_DrawY), 32'd0);
        $display("abort: dropped at (11,2), restart at (%0d,%0d)", bus.clear_DrawX, bus.clear_DrawY);

        // Async reset mid-cycle while presenting (20,20).
        bad = 0;
        for (int i = 0; i < 20 * H + 20; i++) begin
            cmp_pixel(i, bad);
            step();
        end
        check("ar_pre_bad", 32'(bad),             32'd0);
        check("ar_pre_x",   32'(bus.clear_DrawX), 32'd20);
        check("ar_pre_y",   32'(bus.clear_DrawY), 32'd20);
        #3 Reset = 1'b1;
        #1;
        check("ar_we",   32'(bus.pixel_we),    32'd0);
        check("ar_x",    32'(bus.clear_DrawX), 32'd0);
        check("ar_y",    32'(bus.clear_DrawY), 32'd0);
        check("ar_done", 32'(bus.clear_done),  32'd0);
        #1 Reset = 1'b0;
        step();
        check("ar_rs_we", 32'(bus.pixel_we),    32'd1);
        check("ar_rs_x",  32'(bus.clear_DrawX), 32'd0);
        $display("async reset: restarted at (%0d,%0d)", bus.clear_DrawX, bus.clear_DrawY);

        // clear_start falls on the cycle of the final acceptance.
        bad = 0;
        for (int i = 0; i < N - 1; i++) begin
            cmp_pixel(i, bad);
            step();
        end
        check("sim_bad", 32'(bad),             32'd0);
        check("sim_x",   32'(bus.clear_DrawX), 32'(H - 1));
        check("sim_y",   32'(bus.clear_DrawY), 32'(V - 1));
        bus.clear_start = 1'b0;
        step();
        check("sim_done",  32'(bus.clear_done), 32'd1);
        check("sim_we",    32'(bus.pixel_we),   32'd0);
        step();
        check("sim_done2", 32'(bus.clear_done), 32'd0);
        check("sim_we2",   32'(bus.pixel_we),   32'd0);
        $display("simultaneous: Done one cycle then Idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_clearer.md
FRAME_CLEARER -- requirements
Module: frame_clearer

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- CLEAR_COLOR, 16'h0000, background RGB565 value.
- ALT_COLOR, 16'h4208, second checker colour (used only with CLEAR_CHECKER_EN).
- CHECK_SHIFT, 5, log2 of the checker square edge in pixels.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1, sole clock; all state changes on its rising edge.
- Reset, in, 1, asynchronous, active-high reset.
- clear_start, in, 1, level request from the frame control unit; held high for the whole Clear state.
- mem_ready, in, 1, frame-buffer write port accepts the presented pixel this cycle.
- clear_DrawX, out, 10, X address of the presented pixel.
- clear_DrawY, out, 10, Y address of the presented pixel.
- pixel_we, out, 1, a pixel write is presented.
- pixel_color, out, 16, colour of the presented pixel.
- clear_done, out, 1, whole frame cleared.

Function
REQ-003 The FSM SHALL have the states Idle, Run and Done, encoded in 2 bits.
REQ-004 In Idle, outputs SHALL be: pixel_we=0, clear_done=0, clear_DrawX=0, clear_DrawY=0, pixel_color=CLEAR_COLOR.
- Idle->Run when clear_start=1 is sampled.
- The X/Y counters SHALL be 0 on entry to Run.
REQ-005 In Run, pixel_we SHALL be 1 every cycle, and clear_DrawX/clear_DrawY SHALL equal the current counters.
- First pixel_we occurs the cycle after clear_start is first sampled high.
REQ-006 A pixel SHALL be accepted only on a cycle with pixel_we=1 and mem_ready=1.
- Without acceptance, address, colour and pixel_we SHALL hold unchanged (stall).
REQ-007 On acceptance, X SHALL increment.
- If X=H_RES-1, X SHALL wrap to 0 and Y SHALL increment.
- Scan order: raster, X fastest.
REQ-008 Acceptance at (H_RES-1, V_RES-1) SHALL move Run->Done.
- No further pixel_we after that.
- Exactly H_RES*V_RES acceptances per completed clear.
REQ-009 In Done, clear_done SHALL be 1 and pixel_we SHALL be 0.
- Stay in Done while clear_start=1.
- Done->Idle the first cycle clear_start=0 is sampled.
REQ-010 If clear_start=0 is sampled in Run, the FSM SHALL abort to Idle next cycle.
- Counters reset to 0; clear_done is not asserted.
- A pending unaccepted pixel is dropped.
REQ-011 clear_start=1 sampled in the same cycle as the final acceptance SHALL still go to Done.
REQ-012 If clear_start=0 is sampled in the same cycle as the final acceptance, the final acceptance SHALL take precedence and the FSM SHALL go to Done.
- Done then exits to Idle on the next cycle clear_start=0 is sampled.
REQ-013 Counters SHALL be 10-bit unsigned and SHALL never exceed H_RES-1 or V_RES-1.
REQ-014 All outputs SHALL be registered or decoded from registered state only, with no combinational path from mem_ready or clear_start to any output.

Reset
REQ-015 While Reset=1, the module SHALL asynchronously force:
- state = Idle;
- X = Y = 0;
- pixel_we = 0, clear_done = 0, pixel_color = CLEAR_COLOR.
REQ-016 Reset asserted mid-Run SHALL abandon the frame immediately.
- After Reset falls, a new clear requires clear_start to be sampled high in Idle.

Configuration
REQ-017 Macro CLEAR_CHECKER_EN SHALL select the background pattern.
- Defined: pixel_color = ALT_COLOR when bit CHECK_SHIFT of X XOR bit CHECK_SHIFT of Y is 1, else CLEAR_COLOR.
- Undefined: pixel_color = CLEAR_COLOR always, and ALT_COLOR/CHECK_SHIFT are unused.

Verification
REQ-018 Full clear:
- Stimulus: mem_ready tied 1, clear_start raised at cycle 0 and held.
- Response: pixel_we cycles 1..307200, last address (639,479), clear_done=1 from cycle 307201.
- After clear_start drops: Idle one cycle later.
REQ-019 Backpressure:
- Stimulus: mem_ready toggles 1,0,0,1 repeatedly.
- Response: address and colour stable through the 0 cycles, no pixel skipped or duplicated, 307200 acceptances total.
REQ-020 Abort:
- Stimulus: clear_start dropped after acceptance of (100,2).
- Response: pixel_we=0 next cycle, clear_done never 1; a restart begins again at (0,0).
REQ-021 Async reset:
- Stimulus: Reset pulsed mid-cycle during Run at (320,240).
- Response: pixel_we=0 and clear_DrawX=0 before the next Clk edge; FSM in Idle.
REQ-022 Checker (CLEAR_CHECKER_EN defined, defaults):
- (0,0) -> 16'h0000;
- (32,0) -> 16'h4208;
- (32,32) -> 16'h0000.
- Undefined: all pixels 16'h0000.
REQ-023 Simultaneous events:
- Stimulus: clear_start falls in the same cycle as the final acceptance.
- Response: Done for exactly one cycle with clear_done=1, then Idle.
